// File: rtl/fpu_pkg.sv
// Shared FPU definitions: converter FSM encoding and the single-precision
// exponent constants used by int32 <-> float conversion.
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_PACK = 2'd2
  } cvt_state_t;

  localparam logic [7:0]  EXP_BIAS    = 8'd127;
  // Biased exponent of 2^31: first value that no longer fits in int32.
  localparam logic [7:0]  EXP_INT_OVF = 8'd158;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;
  localparam logic [31:0] INT_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] FLT_INT_MIN = 32'hCF00_0000;

endpackage

// File: rtl/fp_cvt_round.sv
// Round-to-nearest-even for the int->float path: rounds the 23-bit mantissa
// taken from a normalised 32-bit shifter and bumps the exponent on carry-out.
module fp_cvt_round
  import fpu_pkg::*;
(
  input  logic [31:0] i_shift,
  input  logic [7:0]  i_exp,
  output logic [22:0] o_mant,
  output logic [7:0]  o_exp
);

  logic        w_guard;
  logic        w_sticky;
  logic        w_up;
  logic        w_carry;
  logic [22:0] w_sum;

  assign w_guard  = i_shift[7];
  assign w_sticky = |i_shift[6:0];
  // Ties go to even: round up on a tie only when the kept LSB is odd.
  assign w_up     = w_guard & (w_sticky | i_shift[8]);
  assign {w_carry, w_sum} = {1'b0, i_shift[30:8]} + {23'd0, w_up};
  assign o_mant   = w_sum;
  assign o_exp    = i_exp + {7'd0, w_carry};

endmodule

// File: rtl/fp_cvt.sv
// Iterative int32 <-> IEEE-754 single converter, one shift per cycle.
// Define FP_CVT_ROUND_EN for round-to-nearest-even on int->float.
module fp_cvt
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dir,
  input  logic [31:0] din,
  output logic        busy,
  output logic        done,
  output logic [31:0] dout,
  output logic        invalid
);

  cvt_state_t  r_state;
  cvt_state_t  w_next;
  logic        r_dir;
  logic        r_sign;
  logic        r_early;
  logic        r_early_inv;
  logic [31:0] r_early_val;
  logic [31:0] r_shift;
  logic [4:0]  r_cnt;
  logic [31:0] r_dout;
  logic        r_inv;

  logic [7:0]  w_e;
  logic [31:0] w_mag;
  logic        w_ovf;
  logic        w_under;
  logic        w_nan;
  logic [31:0] w_sat;
  logic [4:0]  w_tgt;
  logic        w_finish;
  logic [7:0]  w_exp_raw;
  logic [7:0]  w_exp;
  logic [22:0] w_mant;
  logic [31:0] w_result;
  logic        w_res_inv;

  // Operand classification at acceptance.
  assign w_e     = din[30:23];
  assign w_mag   = din[31] ? (~din + 32'd1) : din;
  assign w_ovf   = (w_e == 8'hFF) || ((w_e >= EXP_INT_OVF) && (din != FLT_INT_MIN));
  assign w_under = (w_e < EXP_BIAS);
  assign w_nan   = (w_e == 8'hFF) && (din[22:0] != 23'd0);
  assign w_sat   = (din[31] && !w_nan) ? INT_MIN : INT_MAX;
  assign w_tgt   = 5'(EXP_INT_OVF - w_e);

  // int->float counts shifts up; float->int counts the remaining shifts down.
  assign w_finish  = r_dir ? (r_early || (r_cnt == 5'd0))
                           : (r_shift[31] || (r_shift == 32'd0));
  assign w_exp_raw = EXP_INT_OVF - {3'd0, r_cnt};

`ifdef FP_CVT_ROUND_EN
  fp_cvt_round u_round (
    .i_shift (r_shift),
    .i_exp   (w_exp_raw),
    .o_mant  (w_mant),
    .o_exp   (w_exp)
  );
`else
  assign w_mant = r_shift[30:8];
  assign w_exp  = w_exp_raw;
`endif

  always_comb begin
    w_result  = 32'd0;
    w_res_inv = 1'b0;
    if (r_dir) begin
      if (r_early) begin
        w_result  = r_early_val;
        w_res_inv = r_early_inv;
      end else begin
        w_result  = r_sign ? (~r_shift + 32'd1) : r_shift;
      end
    end else if (r_shift != 32'd0) begin
      w_result = {r_sign, w_exp, w_mant};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_NORM;
      ST_NORM: if (w_finish) w_next = ST_PACK;
      ST_PACK: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir       <= 1'b0;
      r_sign      <= 1'b0;
      r_early     <= 1'b0;
      r_early_inv <= 1'b0;
      r_early_val <= 32'd0;
      r_shift     <= 32'd0;
      r_cnt       <= 5'd0;
      r_dout      <= 32'd0;
      r_inv       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_dir  <= dir;
            r_sign <= din[31];
            if (dir) begin
              r_early     <= w_under || w_ovf;
              r_early_inv <= w_ovf;
              r_early_val <= w_ovf ? w_sat : 32'd0;
              r_shift     <= {1'b1, din[22:0], 8'h00};
              r_cnt       <= w_tgt;
            end else begin
              r_early     <= 1'b0;
              r_early_inv <= 1'b0;
              r_early_val <= 32'd0;
              r_shift     <= w_mag;
              r_cnt       <= 5'd0;
            end
          end
        end
        ST_NORM: begin
          if (w_finish) begin
            r_dout <= w_result;
            r_inv  <= w_res_inv;
          end else if (r_dir) begin
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt - 5'd1;
          end else begin
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == ST_NORM);
  assign done    = (r_state == ST_PACK);
  assign dout    = r_dout;
  assign invalid = r_inv;

endmodule

// File: tb/tb_fp_cvt.sv
// Directed bench for fp_cvt: conversions in both directions, saturation,
// start-while-busy, mid-operation reset and back-to-back requests.
module tb_fp_cvt;

  logic        clk;
  logic        rst;
  logic        start;
  logic        dir;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic [31:0] dout;
  logic        invalid;

  int n_vec;
  int n_err;

  // Results captured by do_op.
  logic [31:0] got_dout;
  logic        got_inv;
  logic        got_busy1;
  logic        got_busy_done;
  logic        got_done_after;
  int          got_cyc;

  fp_cvt dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dir     (dir),
    .din     (din),
    .busy    (busy),
    .done    (done),
    .dout    (dout),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one request (acceptance cycle = 0) and wait for done, bounded.
  // Returns one cycle after done, so the next call starts right after it.
  task automatic do_op(input logic d, input logic [31:0] x);
    int c;
    @(negedge clk);
    start = 1'b1;
    dir   = d;
    din   = x;
    @(posedge clk);
    #1;
    start = 1'b0;
    c = 1;
    got_busy1 = busy;
    while (!done && c < 60) begin
      @(posedge clk);
      #1;
      c++;
    end
    got_cyc       = c;
    got_dout      = dout;
    got_inv       = invalid;
    got_busy_done = busy;
    @(posedge clk);
    #1;
    got_done_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (dout !== 32'd0) begin n_err++; $display("FAIL reset_dout got=%h exp=00000000", dout); end
    n_vec++; if (invalid !== 1'b0) begin n_err++; $display("FAIL reset_invalid got=%b exp=0", invalid); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_int_to_float;
    logic [31:0] v_in  [6] = '{32'h0000_0001, 32'hFFFF_FFFB, 32'h0100_0003,
                               32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
`ifdef FP_CVT_ROUND_EN
    logic [31:0] v_exp [6] = '{32'h3F80_0000, 32'hC0A0_0000, 32'h4B80_0002,
                               32'h0000_0000, 32'hCF00_0000, 32'h4F00_0000};
`else
    logic [31:0] v_exp [6] = '{32'h3F80_0000, 32'hC0A0_0000, 32'h4B80_0001,
                               32'h0000_0000, 32'hCF00_0000, 32'h4EFF_FFFF};
`endif
    int v_cyc [6] = '{33, 31, 9, 2, 2, 3};
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, v_in[i]);
      n_vec++;
      if (got_dout !== v_exp[i]) begin
        n_err++; $display("FAIL i2f_dout[%0d] in=%h got=%h exp=%h", i, v_in[i], got_dout, v_exp[i]);
      end
      n_vec++;
      if (got_cyc != v_cyc[i]) begin
        n_err++; $display("FAIL i2f_cycle[%0d] in=%h got=%0d exp=%0d", i, v_in[i], got_cyc, v_cyc[i]);
      end
      n_vec++;
      if (got_inv !== 1'b0) begin
        n_err++; $display("FAIL i2f_invalid[%0d] got=%b exp=0", i, got_inv);
      end
    end
  endtask

  task automatic test_float_to_int;
    logic [31:0] v_in  [4] = '{32'h4049_0FDB, 32'hC0A0_0000, 32'h3F00_0000, 32'h3F80_0000};
    logic [31:0] v_exp [4] = '{32'h0000_0003, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0001};
    int v_cyc [4] = '{32, 31, 2, 33};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, v_in[i]);
      n_vec++;
      if (got_dout !== v_exp[i]) begin
        n_err++; $display("FAIL f2i_dout[%0d] in=%h got=%h exp=%h", i, v_in[i], got_dout, v_exp[i]);
      end
      n_vec++;
      if (got_inv !== 1'b0) begin
        n_err++; $display("FAIL f2i_invalid[%0d] in=%h got=%b exp=0", i, v_in[i], got_inv);
      end
      n_vec++;
      if (got_cyc != v_cyc[i]) begin
        n_err++; $display("FAIL f2i_cycle[%0d] in=%h got=%0d exp=%0d", i, v_in[i], got_cyc, v_cyc[i]);
      end
    end
  endtask

  task automatic test_saturate;
    logic [31:0] v_in  [5] = '{32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000,
                               32'hCF00_0001, 32'hFF80_0000};
    logic [31:0] v_exp [5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                               32'h8000_0000, 32'h8000_0000};
    logic        v_inv [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_op(1'b1, v_in[i]);
      n_vec++;
      if (got_dout !== v_exp[i]) begin
        n_err++; $display("FAIL sat_dout[%0d] in=%h got=%h exp=%h", i, v_in[i], got_dout, v_exp[i]);
      end
      n_vec++;
      if (got_inv !== v_inv[i]) begin
        n_err++; $display("FAIL sat_invalid[%0d] in=%h got=%b exp=%b", i, v_in[i], got_inv, v_inv[i]);
      end
      n_vec++;
      if (got_cyc != 2) begin
        n_err++; $display("FAIL sat_cycle[%0d] in=%h got=%0d exp=2", i, v_in[i], got_cyc);
      end
    end
  endtask

  task automatic test_handshake;
    do_op(1'b0, 32'h0000_0001);
    n_vec++; if (got_busy1 !== 1'b1) begin n_err++; $display("FAIL busy_after_accept got=%b exp=1", got_busy1); end
    n_vec++; if (got_busy_done !== 1'b0) begin n_err++; $display("FAIL busy_at_done got=%b exp=0", got_busy_done); end
    n_vec++; if (got_done_after !== 1'b0) begin n_err++; $display("FAIL done_pulse_width got=%b exp=0", got_done_after); end
  endtask

  task automatic test_busy_ignore;
    int c;
    int n_done;
    int done_cyc;
    logic [31:0] d_val;
    n_done   = 0;
    done_cyc = 0;
    d_val    = 32'd0;
    @(negedge clk);
    start = 1'b1; dir = 1'b0; din = 32'h0000_0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (c = 1; c <= 45; c++) begin
      if (c == 5) begin start = 1'b1; dir = 1'b1; din = 32'h3F80_0000; end
      if (c == 6) start = 1'b0;
      if (done) begin
        n_done++;
        if (n_done == 1) begin done_cyc = c; d_val = dout; end
      end
      @(posedge clk);
      #1;
    end
    n_vec++; if (n_done != 1) begin n_err++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
    n_vec++; if (done_cyc != 33) begin n_err++; $display("FAIL ignore_done_cycle got=%0d exp=33", done_cyc); end
    n_vec++; if (d_val !== 32'h3F80_0000) begin n_err++; $display("FAIL ignore_dout got=%h exp=3f800000", d_val); end
  endtask

  task automatic test_reset_mid_op;
    int c;
    int n_done;
    n_done = 0;
    @(negedge clk);
    start = 1'b1; dir = 1'b0; din = 32'h0000_0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (c = 1; c < 10; c++) begin
      if (done) n_done++;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_vec++; if (dout !== 32'd0) begin n_err++; $display("FAIL midrst_dout got=%h exp=00000000", dout); end
    n_vec++; if (invalid !== 1'b0) begin n_err++; $display("FAIL midrst_invalid got=%b exp=0", invalid); end
    for (c = 0; c < 40; c++) begin
      if (done) n_done++;
      @(posedge clk);
      #1;
    end
    n_vec++; if (n_done != 0) begin n_err++; $display("FAIL midrst_no_done got=%0d exp=0", n_done); end
    do_op(1'b0, 32'h0000_0002);
    n_vec++; if (got_dout !== 32'h4000_0000) begin n_err++; $display("FAIL midrst_next_dout got=%h exp=40000000", got_dout); end
    n_vec++; if (got_cyc != 32) begin n_err++; $display("FAIL midrst_next_cycle got=%0d exp=32", got_cyc); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v_in  [3] = '{32'h0000_0003, 32'h4040_0000, 32'hFFFF_FFFF};
    logic        v_dir [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] v_exp [3] = '{32'h4040_0000, 32'h0000_0003, 32'hBF80_0000};
    for (int i = 0; i < 3; i++) begin
      do_op(v_dir[i], v_in[i]);
      n_vec++;
      if (got_dout !== v_exp[i]) begin
        n_err++; $display("FAIL b2b_dout[%0d] in=%h got=%h exp=%h", i, v_in[i], got_dout, v_exp[i]);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    dir   = 1'b0;
    din   = 32'd0;
    test_reset();
    test_int_to_float();
    test_float_to_int();
    test_saturate();
    test_handshake();
    test_busy_ignore();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
